framebuffer_writer: RTL and testbench
=====================================

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all ports are listed below, clock and reset first.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 START  input  1  one-cycle pulse requesting capture of one frame.
REQ-005 ABORT  input  1  cancels the frame in progress.
REQ-006 IMG_WIDTH_IN  input  11  frame width in pixels; sampled on an accepted START.
REQ-007 IMG_HEIGHT_IN  input  10  frame height in pixels; sampled on an accepted START.
REQ-008 PIX_DATA  input  8  pixel value from the coprocessor pipeline.
REQ-009 PIX_VALID  input  1  PIX_DATA is valid.
REQ-010 PIX_READY  output  1  block accepts a pixel this cycle.
REQ-011 W_ADDR  output  17  frame-buffer write address.
REQ-012 W_DATA  output  8  frame-buffer write data.
REQ-013 W_EN  output  1  frame-buffer write strobe.
REQ-014 BUSY  output  1  a frame is in progress.
REQ-015 DONE  output  1  one-cycle pulse; frame complete.
REQ-016 ERROR  output  1  one-cycle pulse; START rejected because of invalid dimensions.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WRITE and FINISH.
REQ-018 In IDLE, a START with width in 1..640, height in 1..480 and width*height <= MAX_PIXELS (76800) SHALL latch both dimensions, clear the X, Y and address counters, and enter WRITE.
REQ-019 In IDLE, a START with invalid dimensions SHALL pulse ERROR for one cycle on the next cycle, and the block SHALL remain in IDLE.
REQ-020 START SHALL be ignored outside IDLE.
REQ-021 PIX_READY SHALL be 1 exactly when the state is WRITE; it is decoded combinationally from the state register.
REQ-022 A pixel SHALL be accepted only on a cycle where PIX_VALID and PIX_READY are both 1; PIX_DATA on other cycles SHALL be ignored.
REQ-023 Write latency SHALL be one cycle: W_EN=1 on the cycle after acceptance, with W_ADDR equal to the address counter at acceptance and W_DATA equal to the accepted PIX_DATA.
REQ-024 W_EN SHALL be 0 on every cycle not following an acceptance; gaps in PIX_VALID SHALL produce gaps in W_EN.
REQ-025 Addressing SHALL be row-major starting at 0: address = Y*width + X.
REQ-026 The address SHALL be produced by an incrementing counter; no multiplier is permitted.
REQ-027 On each acceptance X SHALL increment; when X = width-1, X SHALL wrap to 0 and Y SHALL increment.
REQ-028 Acceptance of the pixel at X = width-1, Y = height-1 SHALL move the state to FINISH.
REQ-029 In FINISH, W_EN for the last pixel and DONE SHALL both be 1, and the next state SHALL be IDLE.
REQ-030 BUSY SHALL be 1 in WRITE and FINISH and 0 in IDLE.
REQ-031 ABORT in WRITE SHALL return the block to IDLE on the next cycle, with no DONE pulse.
REQ-032 If a pixel is accepted in the same cycle as ABORT, its write SHALL still be issued; counters then reset on the next START.
REQ-033 ABORT SHALL have priority over last-pixel detection in the same cycle.
REQ-034 A 1x1 frame SHALL go IDLE -> WRITE -> FINISH -> IDLE, producing a single write to address 0.

Reset
REQ-035 Assertion of RST_N low SHALL immediately force state IDLE and set W_EN, DONE, ERROR, BUSY and PIX_READY to 0.
REQ-036 Reset SHALL clear W_ADDR, W_DATA, the X, Y and address counters, and both latched dimensions to 0.
REQ-037 A reset mid-frame SHALL abandon the frame: no further writes and no DONE.
REQ-038 Deassertion of RST_N SHALL take effect on a CLK edge; the first START is accepted no earlier than the first edge after deassertion.

Structure
REQ-039 Shared package fb_pkg SHALL hold: H_DISPLAY=640, V_DISPLAY=480, MAX_PIXELS=76800, the address width (17), the data width (8), and the FSM state enumeration.
REQ-040 The X/Y/address counter SHALL be one sub-module, fb_addr_counter, with clear, increment and width inputs and X, Y, address and last-pixel outputs.
REQ-041 All other logic SHALL reside in framebuffer_writer.

Verification
REQ-042 4x3 frame with PIX_VALID held at 1: 12 writes to addresses 0..11 on consecutive cycles, data matches input order, and DONE coincides with the write to address 11.
REQ-043 4x3 frame with PIX_VALID toggling 1,0,1,0...: writes only after valid beats, and the address sequence is still 0..11 with no skips or repeats.
REQ-044 START with width=0, then with 641x1, then with 320x241: an ERROR pulse each time, BUSY stays 0 and no W_EN.
REQ-045 320x240 frame: the final write is at address 76799 and DONE pulses once; a START issued mid-frame is ignored and the address sequence is unaffected.
REQ-046 RST_N low after 5 pixels of a 4x3 frame: outputs go to 0 immediately; a subsequent START of 2x2 writes addresses 0..3.
REQ-047 ABORT after 6 pixels of a 4x3 frame: the 6th write is issued, there is no DONE, and the block is back in IDLE with BUSY=0 on the next cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, FSM state type and the frame-dimension check for the
// frame-buffer writer.
package fb_pkg;

    localparam int H_DISPLAY  = 640;
    localparam int V_DISPLAY  = 480;
    localparam int MAX_PIXELS = 76800;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int XW         = 11;
    localparam int YW         = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } fb_state_e;

    // A frame is accepted only if it fits on screen and in the buffer.
    function automatic logic dims_valid(input logic [XW-1:0] w, input logic [YW-1:0] h);
        logic [XW+YW-1:0] area;
        area = {{YW{1'b0}}, w} * {{XW{1'b0}}, h};
        return (w != '0) && (h != '0)
            && (w <= XW'(H_DISPLAY)) && (h <= YW'(V_DISPLAY))
            && (area <= (XW+YW)'(MAX_PIXELS));
    endfunction

endpackage

// File: rtl/fb_addr_counter.sv
// Row-major X/Y position and linear write address, advanced one pixel per
// increment; the address is a running count rather than Y*width+X.
module fb_addr_counter
    import fb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              incr_i,
    input  logic [XW-1:0]     width_i,
    input  logic [YW-1:0]     height_i,
    output logic [XW-1:0]     x_o,
    output logic [YW-1:0]     y_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              x_end;

    assign x_end  = (x_q == width_i - XW'(1));
    assign last_o = x_end && (y_q == height_i - YW'(1));

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (incr_i) begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_end) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/framebuffer_writer.sv
// Captures one frame of pixels from a valid/ready stream and writes them
// row-major into a frame buffer with one cycle of latency.
module framebuffer_writer
    import fb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [XW-1:0]     img_width_i,
    input  logic [YW-1:0]     img_height_i,
    input  logic [DATA_W-1:0] pix_data_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic              w_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    // Handshake: a pixel transfers on a rising edge where pix_valid_i and
    // pix_ready_o are both high; pix_ready_o is high for the whole WRITE state.

    fb_state_e         state_q;
    logic [XW-1:0]     width_q;
    logic [YW-1:0]     height_q;
    logic              w_en_q, done_q, error_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [DATA_W-1:0] w_data_q;

    logic              accept, start_ok, cnt_clear, cnt_last;
    logic [XW-1:0]     cnt_x;
    logic [YW-1:0]     cnt_y;
    logic [ADDR_W-1:0] cnt_addr;
    logic              unused_xy;

    assign pix_ready_o = (state_q == ST_WRITE);
    assign busy_o      = (state_q != ST_IDLE);
    assign accept      = pix_ready_o && pix_valid_i;
    assign start_ok    = start_i && dims_valid(img_width_i, img_height_i);
    assign cnt_clear   = (state_q == ST_IDLE) && start_ok;

    fb_addr_counter u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cnt_clear),
        .incr_i   (accept),
        .width_i  (width_q),
        .height_i (height_q),
        .x_o      (cnt_x),
        .y_o      (cnt_y),
        .addr_o   (cnt_addr),
        .last_o   (cnt_last)
    );

    // X/Y are kept on the counter for observation; the address alone drives writes.
    assign unused_xy = ^{cnt_x, cnt_y};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            width_q  <= '0;
            height_q <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            w_en_q  <= accept;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (accept) begin
                w_addr_q <= cnt_addr;
                w_data_q <= pix_data_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        width_q  <= img_width_i;
                        height_q <= img_height_i;
                        state_q  <= ST_WRITE;
                    end else if (start_i) begin
                        error_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // Abort wins over the last pixel; an accepted pixel is still written.
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                    end else if (accept && cnt_last) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end
                end
                ST_FINISH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign w_en_o   = w_en_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;
    assign done_o   = done_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: dimension vectors, directed frames and random
// frames checked against an expected-write queue built from pixel order.
module tb_framebuffer_writer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, abort_i, pix_valid_i;
    logic [10:0] img_width_i;
    logic [9:0]  img_height_i;
    logic [7:0]  pix_data_i;
    logic        pix_ready_o, w_en_o, busy_o, done_o, error_o;
    logic [16:0] w_addr_o;
    logic [7:0]  w_data_o;

    always #5 clk_i = ~clk_i;

    framebuffer_writer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .img_width_i  (img_width_i),
        .img_height_i (img_height_i),
        .pix_data_i   (pix_data_i),
        .pix_valid_i  (pix_valid_i),
        .pix_ready_o  (pix_ready_o),
        .w_addr_o     (w_addr_o),
        .w_data_o     (w_data_o),
        .w_en_o       (w_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
        logic        last;
    } wr_t;

    typedef struct {
        int   w;
        int   h;
        logic err;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (done_o === 1'b1) done_cnt++;
            if (w_en_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write_addr", 32'(w_addr_o), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("w_addr", 32'(w_addr_o), 32'(mon_e.addr));
                    chk("w_data", 32'(w_data_o), 32'(mon_e.data));
                    chk("done_with_write", 32'(done_o), 32'(mon_e.last));
                end
            end else if (done_o !== 1'b0) begin
                chk("done_without_write", 32'(done_o), 32'd0);
            end
        end
    end

    // gap_mode: 0 valid held, 1 valid toggles, 2 random gaps of 0..2 cycles.
    task automatic run_frame(input int w, input int h, input int gap_mode,
                             input int start_at, input int abort_at);
        int n, base, g;
        logic [7:0] d;
        wr_t e;
        n    = w * h;
        base = done_cnt;
        start_i = 1'b1;
        img_width_i  = 11'(w);
        img_height_i = 10'(h);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int idx = 0; idx < n; idx++) begin
            if (gap_mode == 1 && idx > 0) g = 1;
            else if (gap_mode == 2) g = $urandom_range(0, 2);
            else g = 0;
            repeat (g) begin
                pix_valid_i = 1'b0;
                pix_data_i  = 8'($urandom);
                @(posedge clk_i); #1;
            end
            d = 8'($urandom);
            pix_valid_i = 1'b1;
            pix_data_i  = d;
            if (idx == start_at) begin
                start_i = 1'b1;
                img_width_i  = 11'd2;
                img_height_i = 10'd2;
            end
            abort_i = (idx == abort_at);
            e.addr = 17'(idx);
            e.data = d;
            e.last = (idx == n - 1) && (idx != abort_at);
            exp_q.push_back(e);
            @(posedge clk_i); #1;
            start_i = 1'b0;
            abort_i = 1'b0;
            if (idx == abort_at) begin
                pix_valid_i = 1'b0;
                @(negedge clk_i); #1;
                chk("abort_busy", 32'(busy_o), 32'd0);
                chk("abort_ready", 32'(pix_ready_o), 32'd0);
                repeat (3) @(posedge clk_i);
                #1;
                chk("abort_drain", 32'(exp_q.size()), 32'd0);
                chk("abort_no_done", 32'(done_cnt - base), 32'd0);
                return;
            end
        end
        pix_valid_i = 1'b0;
        @(negedge clk_i); #1;
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("busy_finish", 32'(busy_o), 32'd1);
        @(negedge clk_i); #1;
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_done", 32'(done_o), 32'd0);
        chk("frame_drain", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt - base), 32'd1);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0,   1,   1'b1};
        vecs[1] = '{641, 1,   1'b1};
        vecs[2] = '{320, 241, 1'b1};
        vecs[3] = '{4,   0,   1'b1};
        vecs[4] = '{640, 121, 1'b1};
        vecs[5] = '{161, 480, 1'b1};
        vecs[6] = '{640, 120, 1'b0};
        vecs[7] = '{1,   480, 1'b0};
        vecs[8] = '{160, 480, 1'b0};

        rst_ni = 1'b0;
        start_i = 1'b0; abort_i = 1'b0; pix_valid_i = 1'b0;
        img_width_i = '0; img_height_i = '0; pix_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_w_en", 32'(w_en_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_ready", 32'(pix_ready_o), 32'd0);
        chk("rst_addr", 32'(w_addr_o), 32'd0);
        chk("rst_data", 32'(w_data_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        foreach (vecs[i]) begin
            start_i = 1'b1;
            img_width_i  = 11'(vecs[i].w);
            img_height_i = 10'(vecs[i].h);
            @(posedge clk_i); #1;
            start_i = 1'b0;
            @(negedge clk_i); #1;
            chk("vec_error", 32'(error_o), 32'(vecs[i].err));
            chk("vec_busy", 32'(busy_o), 32'(!vecs[i].err));
            chk("vec_ready", 32'(pix_ready_o), 32'(!vecs[i].err));
            chk("vec_no_wen", 32'(w_en_o), 32'd0);
            @(posedge clk_i); #1;
            if (!vecs[i].err) begin
                abort_i = 1'b1;
                @(posedge clk_i); #1;
                abort_i = 1'b0;
            end
            chk("vec_error_one_cycle", 32'(error_o), 32'd0);
            chk("vec_idle_after", 32'(busy_o), 32'd0);
        end

        run_frame(4, 3, 0, -1, -1);
        run_frame(4, 3, 1, -1, -1);
        run_frame(1, 1, 0, -1, -1);
        for (int k = 0; k < 6; k++)
            run_frame($urandom_range(1, 12), $urandom_range(1, 6), 2, -1, -1);
        run_frame(4, 3, 0, -1, 5);
        run_frame(3, 2, 2, -1, 5);

        // Reset while the 5th write of a 4x3 frame is on the bus.
        start_i = 1'b1; img_width_i = 11'd4; img_height_i = 10'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int idx = 0; idx < 5; idx++) begin
            pix_valid_i = 1'b1;
            pix_data_i  = 8'($urandom);
            exp_q.push_back({17'(idx), pix_data_i, 1'b0});
            @(posedge clk_i); #1;
        end
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midrst_w_en", 32'(w_en_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_ready", 32'(pix_ready_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_addr", 32'(w_addr_o), 32'd0);
        chk("midrst_data", 32'(w_data_o), 32'd0);
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        pix_valid_i = 1'b0;
        chk("postrst_idle", 32'(busy_o), 32'd0);
        run_frame(2, 2, 0, -1, -1);

        run_frame(320, 240, 0, 1000, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
